// File: rtl/count_rd_wbm.sv
// Wishbone master that reads a 32-bit counter as four bytes with a coherence re-read of
// the top byte, or pulses a clear via the status register. Optional macro: CNT_RD_TIMEOUT_EN.
module count_rd_wbm #(
    parameter logic [3:0] ADR_STATUS  = 4'h0,
    parameter logic [3:0] ADR_COUNT0  = 4'h1,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  adr_o,
    output logic [7:0]  dat_o,
    input  logic [7:0]  dat_i,
    input  logic        ack_i,
    input  logic        req_i,
    input  logic        clr_i,
    output logic        busy_o,
    output logic [31:0] count_o,
    output logic        valid_o,
    output logic        clr_done_o,
    output logic        err_o
);

    typedef enum logic [3:0] {
        IDLE, RD_HI, RD_B0, RD_B1, RD_B2, RD_HI2, WR_SET, WR_CLR, GAP, DONE
    } state_t;

    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state_q, state_d;
    state_t        nxt_q, nxt_d;       // where GAP resumes
    logic          clr_op_q, clr_op_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    hi_q, hi_d, b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [31:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          bus, ack, timeout;

    assign bus = (state_q == RD_HI) || (state_q == RD_B0) || (state_q == RD_B1) ||
                 (state_q == RD_B2) || (state_q == RD_HI2) || (state_q == WR_SET) ||
                 (state_q == WR_CLR);
    assign ack = bus && ack_i;

`ifdef CNT_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_q, to_d;

    assign timeout = bus && !ack_i && (to_q == TW'(TIMEOUT_CYC - 1));
    assign to_d    = (bus && !ack_i && !timeout) ? to_q + 1'b1 : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) to_q <= '0;
        else       to_q <= to_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        cyc_o = bus;
        stb_o = bus;
        we_o  = 1'b0;
        adr_o = 4'h0;
        dat_o = 8'h00;
        case (state_q)
            RD_HI, RD_HI2: adr_o = ADR_COUNT0 + 4'd3;
            RD_B0:         adr_o = ADR_COUNT0;
            RD_B1:         adr_o = ADR_COUNT0 + 4'd1;
            RD_B2:         adr_o = ADR_COUNT0 + 4'd2;
            WR_SET: begin
                we_o  = 1'b1;
                adr_o = ADR_STATUS;
                dat_o = 8'h01;
            end
            WR_CLR: begin
                we_o  = 1'b1;
                adr_o = ADR_STATUS;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        clr_op_d = clr_op_q;
        retry_d  = retry_q;
        hi_d     = hi_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        count_d  = count_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d  = WR_SET;
                    clr_op_d = 1'b1;
                end else if (req_i) begin
                    state_d  = RD_HI;
                    clr_op_d = 1'b0;
                    retry_d  = '0;
                end
            end
            RD_HI: if (ack) begin
                hi_d    = dat_i;
                state_d = GAP;
                nxt_d   = RD_B0;
            end
            RD_B0: if (ack) begin
                b0_d    = dat_i;
                state_d = GAP;
                nxt_d   = RD_B1;
            end
            RD_B1: if (ack) begin
                b1_d    = dat_i;
                state_d = GAP;
                nxt_d   = RD_B2;
            end
            RD_B2: if (ack) begin
                b2_d    = dat_i;
                state_d = GAP;
                nxt_d   = RD_HI2;
            end
            RD_HI2: if (ack) begin
                // a changed top byte means a carry rippled mid-read; the bytes are torn
                if (dat_i == hi_q) begin
                    count_d = {hi_q, b2_q, b1_q, b0_q};
                    state_d = DONE;
                end else if (retry_q == RW'(MAX_RETRY)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = GAP;
                    nxt_d   = RD_HI;
                end
            end
            WR_SET: if (ack) begin
                state_d = GAP;
                nxt_d   = WR_CLR;
            end
            WR_CLR: if (ack) state_d = DONE;
            GAP:     state_d = nxt_q;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            nxt_q    <= IDLE;
            clr_op_q <= 1'b0;
            retry_q  <= '0;
            hi_q     <= 8'h00;
            b0_q     <= 8'h00;
            b1_q     <= 8'h00;
            b2_q     <= 8'h00;
            count_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nxt_q    <= nxt_d;
            clr_op_q <= clr_op_d;
            retry_q  <= retry_d;
            hi_q     <= hi_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            b2_q     <= b2_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign count_o    = count_q;
    assign valid_o    = (state_q == DONE) && !clr_op_q;
    assign clr_done_o = (state_q == DONE) && clr_op_q;
    assign err_o      = err_q;

endmodule
